ui_input_bank: RTL

UI_INPUT_BANK -- requirements
Module: ui_input_bank

---
 rtl/ui_input_bank_if.sv | 23 ++
 rtl/ui_input_bank.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/ui_input_bank_if.sv
// ui_input_bank_if: groups the pin inputs and event outputs of ui_input_bank.
// master = stimulus side (drives pins/enables), slave = the input bank itself.
interface ui_input_bank_if #(
  parameter int unsigned CHANNELS = 8
);
  logic [CHANNELS-1:0] keys;
  logic [CHANNELS-1:0] chan_en;
  logic [CHANNELS-1:0] level;
  logic [CHANNELS-1:0] press;
  logic [CHANNELS-1:0] rel;
  logic [CHANNELS-1:0] lng;
  logic                any_press;

  modport master (
    output keys, chan_en,
    input  level, press, rel, lng, any_press
  );

  modport slave (
    input  keys, chan_en,
    output level, press, rel, lng, any_press
  );
endinterface

// File: rtl/ui_input_bank.sv
// ui_input_bank: bank of independent button/switch inputs. Each channel is
// synchronised, polarity-normalised and debounced, and produces press,
// release and long-press pulses from a shared hold-time prescaler.
// Optional feature macro: UI_INPUT_BANK_REPEAT_EN -- auto-repeat o_press
// every REPEAT_TICKS ticks after the long-press event while held.
module ui_input_bank #(
  parameter int unsigned         CHANNELS     = 8,
  parameter int unsigned         CNT_MAX      = 20'hFFFFF,
  parameter logic [CHANNELS-1:0] ACTIVE_HIGH  = {CHANNELS{1'b1}},
  parameter int unsigned         TICK_DIV     = 100000,
  parameter int unsigned         LONG_TICKS   = 1000,
  parameter int unsigned         REPEAT_TICKS = 100
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [CHANNELS-1:0] i_keys,
  input  logic [CHANNELS-1:0] i_chan_en,
  output logic [CHANNELS-1:0] o_level,
  output logic [CHANNELS-1:0] o_press,
  output logic [CHANNELS-1:0] o_release,
  output logic [CHANNELS-1:0] o_long,
  output logic                o_any_press
);

  localparam int unsigned DW = $clog2(CNT_MAX + 1);
  localparam int unsigned HW = $clog2(LONG_TICKS + 1);
  localparam int unsigned PW = $clog2(TICK_DIV);
`ifdef UI_INPUT_BANK_REPEAT_EN
  localparam int unsigned RW = $clog2(REPEAT_TICKS + 1);
`endif
  // Raw pin value that corresponds to an inactive (idle) input.
  localparam logic [CHANNELS-1:0] IDLE_PIN = ~ACTIVE_HIGH;

  // Elaboration-time guard on the legal parameter ranges.
  if (CHANNELS < 1 || CHANNELS > 32 || CNT_MAX < 1 || TICK_DIV < 2 ||
      LONG_TICKS < 1 || REPEAT_TICKS < 1) begin : g_param_check
    $error("ui_input_bank: parameter out of range");
  end

  logic [CHANNELS-1:0] sync1_q, sync1_d;
  logic [CHANNELS-1:0] sync2_q, sync2_d;
  logic [DW-1:0]       cnt_q  [CHANNELS];
  logic [DW-1:0]       cnt_d  [CHANNELS];
  logic [HW-1:0]       hold_q [CHANNELS];
  logic [HW-1:0]       hold_d [CHANNELS];
`ifdef UI_INPUT_BANK_REPEAT_EN
  logic [RW-1:0]       rep_q  [CHANNELS];
  logic [RW-1:0]       rep_d  [CHANNELS];
`endif
  logic [PW-1:0]       pre_q, pre_d;
  logic [CHANNELS-1:0] level_q, level_d;
  logic [CHANNELS-1:0] press_q, press_d;
  logic [CHANNELS-1:0] release_q, release_d;
  logic [CHANNELS-1:0] long_q, long_d;
  logic                any_q, any_d;

  logic                tick_c;
  logic [CHANNELS-1:0] norm_c;
  logic [CHANNELS-1:0] mismatch_c;
  logic [CHANNELS-1:0] toggle_c;

  // Next-state: prescaler, per-channel debounce, hold timing and events.
  always_comb begin
    tick_c     = (pre_q == PW'(TICK_DIV - 1));
    pre_d      = tick_c ? '0 : pre_q + PW'(1);
    norm_c     = sync2_q ^ ~ACTIVE_HIGH;
    sync1_d    = IDLE_PIN;
    sync2_d    = IDLE_PIN;
    mismatch_c = '0;
    toggle_c   = '0;
    level_d    = '0;
    press_d    = '0;
    release_d  = '0;
    long_d     = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i]  = '0;
      hold_d[i] = '0;
`ifdef UI_INPUT_BANK_REPEAT_EN
      rep_d[i]  = '0;
`endif
      // A disabled channel stays parked in its reset state.
      if (i_chan_en[i]) begin
        sync1_d[i]    = i_keys[i];
        sync2_d[i]    = sync1_q[i];
        mismatch_c[i] = norm_c[i] ^ level_q[i];
        toggle_c[i]   = mismatch_c[i] && (cnt_q[i] == DW'(CNT_MAX));
        if (mismatch_c[i] && !toggle_c[i]) begin
          cnt_d[i] = cnt_q[i] + DW'(1);
        end
        level_d[i]   = level_q[i] ^ toggle_c[i];
        press_d[i]   = toggle_c[i] & ~level_q[i];
        release_d[i] = toggle_c[i] & level_q[i];
        if (level_q[i]) begin
          hold_d[i] = hold_q[i];
          if (tick_c && (hold_q[i] != HW'(LONG_TICKS))) begin
            hold_d[i] = hold_q[i] + HW'(1);
          end
          // No long event on the same edge the key is released.
          long_d[i] = tick_c && (hold_q[i] == HW'(LONG_TICKS - 1)) && !toggle_c[i];
`ifdef UI_INPUT_BANK_REPEAT_EN
          rep_d[i] = rep_q[i];
          if (tick_c && (hold_q[i] == HW'(LONG_TICKS))) begin
            if (rep_q[i] == RW'(REPEAT_TICKS - 1)) begin
              rep_d[i]   = '0;
              press_d[i] = !toggle_c[i];
            end else begin
              rep_d[i] = rep_q[i] + RW'(1);
            end
          end
`endif
        end
      end
    end
    any_d = |press_d;
  end

  // State and output registers; synchronisers reset to the idle pin value.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q   <= IDLE_PIN;
      sync2_q   <= IDLE_PIN;
      pre_q     <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      long_q    <= '0;
      any_q     <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i]  <= '0;
        hold_q[i] <= '0;
`ifdef UI_INPUT_BANK_REPEAT_EN
        rep_q[i]  <= '0;
`endif
      end
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      pre_q     <= pre_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      any_q     <= any_d;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i]  <= cnt_d[i];
        hold_q[i] <= hold_d[i];
`ifdef UI_INPUT_BANK_REPEAT_EN
        rep_q[i]  <= rep_d[i];
`endif
      end
    end
  end

  assign o_level     = level_q;
  assign o_press     = press_q;
  assign o_release   = release_q;
  assign o_long      = long_q;
  assign o_any_press = any_q;

endmodule
